// File: rtl/umi_putc_pkg.sv
// Opcode constants and the default character-sink address shared by the
// UMI putc sink and its testbench.
package umi_putc_pkg;

  typedef enum logic [4:0] {
    REQ_READ     = 5'h01,
    REQ_WRITE    = 5'h03,
    REQ_WRPOSTED = 5'h05
  } umi_opcode_e;

  localparam logic [63:0] PUTC_ADDR_DEFAULT = 64'h1000000;

endpackage

// File: rtl/umi_putc_fifo.sv
// Synchronous FIFO with registered occupancy.
// No fall-through: data becomes visible the cycle after the push.
module umi_putc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [WIDTH-1:0] wdata,
  input  logic          pop,
  output logic [WIDTH-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             doPush, doPop;

  assign full   = (level_q == LW'(DEPTH));
  assign empty  = (level_q == '0);
  assign level  = level_q;
  assign rdata  = mem_q[rdPtr_q];
  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (doPush) wrPtr_d = wrPtr_q + AW'(1);
    if (doPop)  rdPtr_d = rdPtr_q + AW'(1);
    level_d = level_q + LW'(doPush) - LW'(doPop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= wdata;
  end

endmodule

// File: rtl/umi_putc_sink.sv
// UMI device endpoint that turns posted writes to one address into a
// byte stream; every other accepted request is dropped and counted.
module umi_putc_sink
  import umi_putc_pkg::*;
#(
  parameter int CMD_WIDTH  = 32,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 16,
  parameter logic [ADDR_WIDTH-1:0] PUTC_ADDR = ADDR_WIDTH'(PUTC_ADDR_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  udev_req_valid,
  input  logic [CMD_WIDTH-1:0]  udev_req_cmd,
  input  logic [ADDR_WIDTH-1:0] udev_req_dstaddr,
  input  logic [ADDR_WIDTH-1:0] udev_req_srcaddr,
  input  logic [DATA_WIDTH-1:0] udev_req_data,
  output logic                  udev_req_ready,
  output logic                  char_valid,
  output logic [7:0]            char_data,
  input  logic                  char_ready,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [15:0]           drop_count
);

  logic        outOfReset_q;
  logic [15:0] dropCount_q, dropCount_d;
  logic        full, empty;
  logic        accept, isPutc, push, drop;
  logic        unusedInputs;

  assign unusedInputs = ^{udev_req_srcaddr, udev_req_data[DATA_WIDTH-1:8],
                          udev_req_cmd[CMD_WIDTH-1:5]};

  // Ready comes only from registers, so it holds low through the reset
  // cycle and rises once the first non-reset edge has been seen.
  assign udev_req_ready = outOfReset_q && !full;
  assign accept = udev_req_valid && udev_req_ready;
  assign isPutc = (udev_req_cmd[4:0] == 5'(REQ_WRPOSTED)) &&
                  (udev_req_dstaddr == PUTC_ADDR);
  assign push   = accept && isPutc;
  assign drop   = accept && !isPutc;
  assign char_valid = !empty;
  assign drop_count = dropCount_q;

  always_comb begin
    dropCount_d = dropCount_q;
    if (drop && (dropCount_q != 16'hFFFF)) dropCount_d = dropCount_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outOfReset_q <= 1'b0;
      dropCount_q  <= '0;
    end else begin
      outOfReset_q <= 1'b1;
      dropCount_q  <= dropCount_d;
    end
  end

  umi_putc_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (udev_req_data[7:0]),
    .pop   (char_ready),
    .rdata (char_data),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_umi_putc_sink.sv
// Directed bench for umi_putc_sink: a queue-based reference model is checked
// every cycle, and literal expectations pin the scenario outcomes.
module tb_umi_putc_sink;

  localparam int DEPTH = 16;
  localparam logic [63:0] PUTC = 64'h1000000;

  logic         clk;
  logic         reset;
  logic         udev_req_valid;
  logic [31:0]  udev_req_cmd;
  logic [63:0]  udev_req_dstaddr;
  logic [63:0]  udev_req_srcaddr;
  logic [127:0] udev_req_data;
  logic         udev_req_ready;
  logic         char_valid;
  logic [7:0]   char_data;
  logic         char_ready;
  logic [4:0]   fifo_level;
  logic [15:0]  drop_count;

  int checks = 0;
  int errors = 0;

  umi_putc_sink dut (
    .clk              (clk),
    .reset            (reset),
    .udev_req_valid   (udev_req_valid),
    .udev_req_cmd     (udev_req_cmd),
    .udev_req_dstaddr (udev_req_dstaddr),
    .udev_req_srcaddr (udev_req_srcaddr),
    .udev_req_data    (udev_req_data),
    .udev_req_ready   (udev_req_ready),
    .char_valid       (char_valid),
    .char_data        (char_data),
    .char_ready       (char_ready),
    .fifo_level       (fifo_level),
    .drop_count       (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: a byte queue plus a drop tally, updated per spec rules.
  logic [7:0] modelQ[$];
  int         modelDrops = 0;
  bit         modelInReset = 1'b1;
  bit         checkEn = 1'b0;
  bit         mAcc, mHit;
  logic [7:0] outLog[$];

  always @(posedge clk) begin
    if (reset) begin
      modelQ.delete();
      modelDrops   = 0;
      modelInReset = 1'b1;
      checkEn      = 1'b1;
    end else begin
      mAcc = udev_req_valid && !modelInReset && (modelQ.size() < DEPTH);
      mHit = (udev_req_cmd[4:0] == 5'h05) && (udev_req_dstaddr == PUTC);
      if (char_ready && modelQ.size() > 0) void'(modelQ.pop_front());
      if (mAcc && mHit) modelQ.push_back(udev_req_data[7:0]);
      else if (mAcc && modelDrops < 65535) modelDrops++;
      modelInReset = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (!reset && char_valid && char_ready) outLog.push_back(char_data);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn && !reset) begin
      checkOutput("model.level", 32'(fifo_level), 32'(modelQ.size()));
      checkOutput("model.charValid", 32'(char_valid), 32'(modelQ.size() > 0));
      checkOutput("model.ready", 32'(udev_req_ready),
                  32'(!modelInReset && modelQ.size() < DEPTH));
      checkOutput("model.drops", 32'(drop_count), 32'(modelDrops));
      if (modelQ.size() > 0) checkOutput("model.charData", 32'(char_data), 32'(modelQ[0]));
    end
  end

  task automatic applyStimulus(input logic v, input logic [4:0] op,
                               input logic [63:0] addr, input logic [7:0] d);
    @(negedge clk); #1;
    udev_req_valid   = v;
    udev_req_cmd     = {27'd0, op};
    udev_req_dstaddr = addr;
    udev_req_data    = {120'h5A5A, d};
  endtask

  task automatic sendReq(input logic [4:0] op, input logic [63:0] addr, input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    for (int w = 0; w < 100 && !ok; w++) begin
      applyStimulus(1'b1, op, addr, d);
      if (udev_req_ready) begin
        @(posedge clk);
        ok = 1'b1;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL sendReq.timeout: byte 0x%0h not accepted, required within 100 cycles", d);
    end
  endtask

  task automatic idleCycles(input int n);
    applyStimulus(1'b0, 5'h00, 64'd0, 8'h00);
    repeat (n) @(negedge clk);
    #1;
  endtask

  string msg;
  logic [7:0] expSeq[$];

  initial begin
    reset = 1'b1;
    udev_req_valid = 1'b0;
    udev_req_cmd = '0;
    udev_req_dstaddr = '0;
    udev_req_srcaddr = 64'hDEAD_BEEF_0000_1234;
    udev_req_data = '0;
    char_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checkOutput("reset.level", 32'(fifo_level), 32'd0);
    checkOutput("reset.charValid", 32'(char_valid), 32'd0);
    checkOutput("reset.drops", 32'(drop_count), 32'd0);
    checkOutput("reset.ready", 32'(udev_req_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk); #1;
    checkOutput("afterReset.ready", 32'(udev_req_ready), 32'd1);

    // Hello World stream with the consumer always ready.
    msg = "Hello World!\n";
    char_ready = 1'b1;
    outLog.delete();
    for (int i = 0; i < msg.len(); i++) sendReq(5'h05, PUTC, msg[i]);
    idleCycles(4);
    checkOutput("hello.count", 32'(outLog.size()), 32'd13);
    for (int i = 0; i < msg.len() && i < outLog.size(); i++)
      checkOutput($sformatf("hello.char%0d", i), 32'(outLog[i]), 32'(msg[i]));
    checkOutput("hello.drops", 32'(drop_count), 32'd0);

    // Fill to capacity with the consumer stalled.
    char_ready = 1'b0;
    outLog.delete();
    for (int i = 0; i < 16; i++) sendReq(5'h05, PUTC, 8'h40 + 8'(i));
    @(negedge clk); #1;
    checkOutput("full.ready", 32'(udev_req_ready), 32'd0);
    checkOutput("full.level", 32'(fifo_level), 32'd16);
    applyStimulus(1'b1, 5'h05, PUTC, 8'h50);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("full.held", 32'(fifo_level), 32'd16);
    char_ready = 1'b1;
    for (int i = 16; i < 20; i++) sendReq(5'h05, PUTC, 8'h40 + 8'(i));
    idleCycles(25);
    checkOutput("full.count", 32'(outLog.size()), 32'd20);
    for (int i = 0; i < 20 && i < outLog.size(); i++)
      checkOutput($sformatf("full.byte%0d", i), 32'(outLog[i]), 32'h40 + 32'(i));

    // Non-matching opcode or address requests are dropped.
    outLog.delete();
    sendReq(5'h03, PUTC, 8'h58);
    sendReq(5'h05, PUTC + 64'd8, 8'h59);
    sendReq(5'h01, PUTC, 8'h5A);
    idleCycles(2);
    checkOutput("drop.count", 32'(drop_count), 32'd3);
    checkOutput("drop.level", 32'(fifo_level), 32'd0);
    checkOutput("drop.noOutput", 32'(outLog.size()), 32'd0);

    // Simultaneous push and pop at level 5 across pointer wrap.
    char_ready = 1'b0;
    outLog.delete();
    expSeq.delete();
    for (int i = 0; i < 5; i++) begin
      sendReq(5'h05, PUTC, 8'h60 + 8'(i));
      expSeq.push_back(8'h60 + 8'(i));
    end
    idleCycles(1);
    checkOutput("pushPop.startLevel", 32'(fifo_level), 32'd5);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, 5'h05, PUTC, 8'h70 + 8'(k));
      char_ready = 1'b1;
      expSeq.push_back(8'h70 + 8'(k));
      @(negedge clk); #1;
      char_ready = 1'b0;
      udev_req_valid = 1'b0;
      checkOutput($sformatf("pushPop.level%0d", k), 32'(fifo_level), 32'd5);
    end
    char_ready = 1'b1;
    idleCycles(10);
    checkOutput("pushPop.count", 32'(outLog.size()), 32'd25);
    for (int i = 0; i < expSeq.size() && i < outLog.size(); i++)
      checkOutput($sformatf("pushPop.byte%0d", i), 32'(outLog[i]), 32'(expSeq[i]));

    // Mid-stream reset with a request presented in the same cycle.
    char_ready = 1'b0;
    for (int i = 0; i < 8; i++) sendReq(5'h05, PUTC, 8'h90 + 8'(i));
    idleCycles(1);
    checkOutput("midReset.before", 32'(fifo_level), 32'd8);
    reset = 1'b1;
    udev_req_valid = 1'b1;
    udev_req_cmd = 32'h5;
    udev_req_dstaddr = PUTC;
    udev_req_data = 128'hAA;
    @(negedge clk); #1;
    reset = 1'b0;
    udev_req_valid = 1'b0;
    checkOutput("midReset.level", 32'(fifo_level), 32'd0);
    checkOutput("midReset.charValid", 32'(char_valid), 32'd0);
    checkOutput("midReset.ready", 32'(udev_req_ready), 32'd0);
    checkOutput("midReset.drops", 32'(drop_count), 32'd0);
    @(negedge clk); #1;
    checkOutput("midReset.readyBack", 32'(udev_req_ready), 32'd1);
    checkOutput("midReset.notAccepted", 32'(fifo_level), 32'd0);

    // Drop counter saturation.
    applyStimulus(1'b1, 5'h01, PUTC, 8'h00);
    repeat (65534) @(posedge clk);
    @(negedge clk); #1;
    checkOutput("sat.nearMax", 32'(drop_count), 32'hFFFE);
    repeat (6) @(posedge clk);
    @(negedge clk); #1;
    checkOutput("sat.held", 32'(drop_count), 32'hFFFF);
    idleCycles(2);
    checkOutput("sat.level", 32'(fifo_level), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/umi_putc_sink.md
UMI_PUTC_SINK -- requirements
Module: umi_putc_sink

Interface
REQ-001 Parameter CMD_WIDTH, default 32, UMI command width.
REQ-002 Parameter ADDR_WIDTH, default 64, UMI address width.
REQ-003 Parameter DATA_WIDTH, default 128, UMI data width.
REQ-004 Parameter DEPTH, default 16, character FIFO depth; power of two, 2 or more.
REQ-005 Parameter PUTC_ADDR, default 64'h1000000, character-sink address.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 reset  input  1  one clock; reset is synchronous and active-high.
REQ-008 udev_req_valid  input  1  UMI request valid.
REQ-009 udev_req_cmd  input  CMD_WIDTH  UMI command; opcode in cmd[4:0].
REQ-010 udev_req_dstaddr  input  ADDR_WIDTH  destination address.
REQ-011 udev_req_srcaddr  input  ADDR_WIDTH  source address; ignored.
REQ-012 udev_req_data  input  DATA_WIDTH  payload; only data[7:0] used.
REQ-013 udev_req_ready  output  1  request accepted when valid && ready.
REQ-014 char_valid  output  1  character available.
REQ-015 char_data  output  8  character byte.
REQ-016 char_ready  input  1  consumer accepts when char_valid && char_ready.
REQ-017 fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-018 drop_count  output  16  saturating count of discarded requests.

Function
REQ-019 udev_req_ready SHALL equal !full, registered state only, with no combinational path from any udev_req_* input.
REQ-020 An accepted request with cmd[4:0]==5'h05 (posted write) and dstaddr==PUTC_ADDR SHALL push data[7:0] into the FIFO.
REQ-021 Any other accepted request SHALL be discarded with no FIFO change and SHALL increment drop_count. This covers a non-matching opcode, including 0x01 read and 0x03 non-posted write, or a non-matching address.
REQ-022 drop_count SHALL saturate at 16'hFFFF.
REQ-023 Non-posted requests SHALL NOT generate a response; the block has no response port.
REQ-024 char_valid SHALL be !empty; char_data SHALL be the oldest entry, stable while char_valid && !char_ready.
REQ-025 Latency from an accepting cycle to char_valid on an empty FIFO SHALL be exactly 1 cycle; there is no fall-through in the same cycle.
REQ-026 A push and pop in the same cycle SHALL leave fifo_level unchanged and preserve order.
REQ-027 When full, udev_req_ready=0, so no push occurs; a pop while full SHALL raise ready in the next cycle.
REQ-028 A pop while empty SHALL be ignored.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH.
REQ-030 fifo_level SHALL range 0..DEPTH; full is level==DEPTH and empty is level==0.

Reset
REQ-031 While reset=1 at a clock edge, the FIFO SHALL be emptied: fifo_level=0, char_valid=0, drop_count=0, and udev_req_ready=0.
REQ-032 udev_req_ready SHALL assert the first cycle after reset deasserts.
REQ-033 Reset asserted mid-stream SHALL discard all buffered characters, and any request presented that cycle SHALL NOT be accepted.
REQ-034 FIFO storage contents need no reset.

Structure
REQ-035 The shared package umi_putc_pkg SHALL hold the opcode constants (REQ_READ 0x01, REQ_WRITE 0x03, REQ_WRPOSTED 0x05) and the default PUTC_ADDR.
REQ-036 The FIFO SHALL be the sub-module umi_putc_fifo (synchronous, parameterised WIDTH/DEPTH, exposing full, empty and level); decode and counters stay in the top module.

Verification
REQ-037 Stream "Hello World!\n" (13 posted writes to 0x1000000) with char_ready=1: 13 chars out in order, drop_count=0.
REQ-038 Hold char_ready=0 and send 20 writes: exactly 16 accepted, ready=0 from the cycle after the 16th, level=16; release char_ready and the remaining 4 are accepted in order.
REQ-039 Send opcode 0x03 to 0x1000000, then 0x05 to 0x1000008, then 0x01 to 0x1000000: FIFO untouched, drop_count=3.
REQ-040 At level 5, push and pop in the same cycle: level stays 5 and the output byte order is intact across pointer wrap.
REQ-041 At level 8, assert reset for 1 cycle with valid=1: level=0, char_valid=0, the request is not accepted, and ready=1 the next cycle.
REQ-042 Force 65536 drops: drop_count holds 16'hFFFF.
